// File: rtl/mos_arb_pkg.sv
// rtl/mos_arb_pkg.sv - shared types and helpers for the transmission-gate switch arbiter
package mos_arb_pkg;

  // Largest supported requester count; helpers work on this width and callers truncate.
  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    ON    = 2'd2
  } arb_state_e;

  // Bits needed to index n items (at least 1).
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the value v (at least 1).
  function automatic int cnt_width(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [3:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting just after the last owner
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  input  logic [N-1:0] mask,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [N-1:0] cand;

  // Lowest candidate above last wins; otherwise wrap to the lowest at or below last.
  always_comb begin
    cand  = req & ~mask;
    valid = 1'b0;
    idx   = '0;
    // Wrapped half first so any hit in the upper half overrides it.
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[k] && (k <= int'(last))) begin
        valid = 1'b1;
        idx   = W'(k);
      end
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[k] && (k > int'(last))) begin
        valid = 1'b1;
        idx   = W'(k);
      end
    end
  end

endmodule

// File: rtl/mos_switch_arbiter.sv
// rtl/mos_switch_arbiter.sv - break-before-make round-robin owner of a shared switched net
module mos_switch_arbiter
  import mos_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DEAD_CYC = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  output logic [N_REQ-1:0]              grant,
  output logic [N_REQ-1:0]              nctrl,
  output logic [N_REQ-1:0]              pctrl,
  output logic [idx_width(N_REQ)-1:0]   owner,
  output logic                          busy
);

  localparam int OW = idx_width(N_REQ);
  localparam int DW = cnt_width(DEAD_CYC);
  localparam int HW = cnt_width(MAX_HOLD);

  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYC - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

  arb_state_e       state;
  logic [OW-1:0]    last;
  logic [DW-1:0]    dead_cnt;
  logic [HW-1:0]    hold_cnt;

  logic [N_REQ-1:0] owner_oh;
  logic             owner_req;
  logic             others_pending;
  logic             hold_expired;
  logic             release_now;
  logic [N_REQ-1:0] pick_mask;
  logic             pick_valid;
  logic [OW-1:0]    pick_idx;

  // Release decision; the owner is masked from the next pick only when it is being preempted.
  always_comb begin
    owner_oh       = N_REQ'(idx_to_onehot(4'(owner)));
    owner_req      = |(req & owner_oh);
    others_pending = |(req & ~owner_oh);
    hold_expired   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    release_now    = !owner_req || (hold_expired && others_pending);
    pick_mask      = ((state == ON) && owner_req) ? owner_oh : '0;
  end

  rr_pick #(
    .N (N_REQ),
    .W (OW)
  ) u_pick (
    .req   (req),
    .last  (last),
    .mask  (pick_mask),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Arbitration FSM; every switch control is a register so req never reaches a gate combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      nctrl    <= '0;
      pctrl    <= '1;
      owner    <= '0;
      busy     <= 1'b0;
      last     <= OW'(N_REQ - 1);
      dead_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= GUARD;
            owner    <= pick_idx;
            dead_cnt <= DEAD_LOAD;
            busy     <= 1'b1;
          end
        end
        GUARD: begin
          // The owner's request is deliberately not rechecked here; it gets at least one ON cycle.
          if (dead_cnt == '0) begin
            state    <= ON;
            grant    <= owner_oh;
            nctrl    <= owner_oh;
            pctrl    <= ~owner_oh;
            last     <= owner;
            hold_cnt <= '0;
          end else begin
            dead_cnt <= dead_cnt - 1'b1;
          end
        end
        ON: begin
          if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
          if (release_now) begin
            grant <= '0;
            nctrl <= '0;
            pctrl <= '1;
            if (pick_valid) begin
              state    <= GUARD;
              owner    <= pick_idx;
              dead_cnt <= DEAD_LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          nctrl <= '0;
          pctrl <= '1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mos_switch_arbiter.md
# mos_switch_arbiter

Round-robin arbiter that shares one tri-state net, driven through N CMOS transmission-gate switches, between N requesters. It produces the complementary gate controls (`nctrl` active-high, `pctrl` active-low) for each switch. It enforces break-before-make dead time so no two switches ever conduct in the same cycle, and caps how long one owner can hold the net. It sits between requesting logic and the bank of `cmos` switch primitives whose outputs are tied to the shared net.

## Interface
- `N_REQ`, 4: number of requesters/switches (2..16).
- `DEAD_CYC`, 2: all-off guard cycles before any switch turns on (≥1).
- `MAX_HOLD`, 16: maximum ON cycles while another request is pending; 0 disables preemption.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  N_REQ  level request per requester; held high while it wants the net.
- `grant`  out  N_REQ  one-hot or zero; bit i high while switch i conducts.
- `nctrl`  out  N_REQ  NMOS gate controls; equals `grant`.
- `pctrl`  out  N_REQ  PMOS gate controls; equals `~grant`.
- `owner`  out  clog2(N_REQ)  index of the current or next owner; valid while `busy`.
- `busy`  out  1  high in GUARD and ON.

## Operation
- States:
  - IDLE: all switches off.
  - GUARD: all switches off; a dead-time counter runs.
  - ON: exactly one switch conducts.
- All outputs are registered and decoded from the state, `owner` and the grant register. There is no combinational path from `req` to any output.
- Arbitration (pick):
  - Candidates are the `req` bits, searched from `last+1` mod N_REQ upward with wrap-around.
  - `last` is the most recent ON owner; its reset value is N_REQ-1, so index 0 has first priority.
- IDLE → GUARD: at an edge where `req != 0`. Latch `owner` = pick and load counter = DEAD_CYC-1.
- GUARD:
  - The counter decrements each edge.
  - At the edge where the counter is 0: go to ON, set `grant[owner]`, set `last` = `owner`, clear the hold counter.
  - `req[owner]` is not rechecked in GUARD. If the owner drops its request during GUARD, it still receives a 1-cycle ON before release.
- ON: the hold counter increments each edge and saturates at MAX_HOLD.
- Release condition, evaluated at each edge in ON:
  - `req[owner] == 0`, or
  - MAX_HOLD ≠ 0, the hold counter equals MAX_HOLD-1, and `(req & ~onehot(owner)) != 0`.
- On release:
  - `grant` clears at that edge.
  - If other requests are pending (mask out `owner` only when preempting), go to GUARD with a new pick.
  - Otherwise go to IDLE.
- A preempted owner whose `req` is still high competes normally and gets lowest priority next round.
- Simultaneous requests: exactly one winner per the round-robin order.
- Reset mid-operation: at the reset edge, state returns to IDLE and `grant` = 0. Switches go off at that edge with no dead-time wait.
- Reset values: `grant`=0, `nctrl`=0, `pctrl`=all ones, `owner`=0, `busy`=0, `last`=N_REQ-1, both counters 0.

## Timing
- Request latency: `req` first sampled high at edge E0 from IDLE → `grant` high after edge E0+DEAD_CYC.
- Release: `req[owner]` sampled low at edge Er → `grant` low after Er.
- Handover: the next grant rises no earlier than after edge Er+DEAD_CYC. There are exactly DEAD_CYC all-off cycles between conducting intervals on a direct handover.
- Preemption: with others pending, the owner conducts exactly MAX_HOLD cycles.
- Invariant: `grant` is never more than one-hot, and `pctrl == ~nctrl` every cycle.

## Structure
- Package `mos_arb_pkg`:
  - state enum (IDLE, GUARD, ON);
  - width helper for `owner` and counters;
  - one-hot/index conversion functions.
- One combinational sub-module, `rr_pick`. Inputs: `req`, `last`, optional `mask`. Outputs: `valid`, `idx`.
- Top level holds the FSM, counters and output registers.

## Test plan
- Reset: hold `rst` 2 cycles → `grant`=0000, `pctrl`=1111, `busy`=0. Assert `rst` while ON for requester 2 → `grant`=0000 the next cycle.
- Single request, DEAD_CYC=2: `req`=0100 from cycle 5 → `grant`=0100 after edge 7. Drop `req` at edge 12 → `grant`=0000 after edge 12, state IDLE.
- Simultaneous requests: `req`=1011 held, each requester drops its request 3 cycles after its grant → grant order 0001, 0010, 1000. Every gap is exactly 2 all-off cycles; `grant` is never multi-hot.
- Preemption, MAX_HOLD=4: `req`=0011 held → owner 0 conducts 4 cycles, owner 1 conducts 4 cycles, then owner 0 again. Repeats with 2-cycle gaps.
- Preemption disabled, MAX_HOLD=0: `req`=0011 held for 50 cycles → owner 0 holds for all 50 cycles.
- Drop during GUARD: `req`=0001 for one cycle only → a 1-cycle `grant`=0001, then IDLE. Randomized assertion check over 10k cycles: `pctrl == ~nctrl` always and at most one `grant` bit set.
